multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter MEM_WAIT_EN, default 1: when 1, memory states wait for mem_ready; when 0, mem_ready is treated as constantly 1.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port op, input, 6 bits: opcode field instr[31:26] from the instruction register.
REQ-005 The block SHALL have port mem_ready, input, 1 bit: memory completes the current access this cycle.
REQ-006 The block SHALL have ports pc_write, pc_write_cond, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a and ext_sel, each an output of 1 bit; ext_sel=1 selects sign-extension of the 16-bit immediate and ext_sel=0 selects zero-extension.
REQ-007 The block SHALL have ports alu_src_b, alu_op and pc_src, each an output of 2 bits.
REQ-008 The block SHALL have port illegal_op, output, 1 bit: one-cycle pulse on an unsupported opcode.

Function
REQ-009 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, IMMEXEC, IMMWB and JUMP.
REQ-010 FETCH SHALL drive iord=0, alu_src_a=0, alu_src_b=01, alu_op=00 and pc_src=00; ir_write and pc_write SHALL be 1 only in the cycle mem_ready=1; the FSM SHALL stay in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-011 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=00 and ext_sel=1 (branch target precompute), then branch on op.
REQ-012 From DECODE, op 100011 (lw) and 101011 (sw) SHALL go to MEMADR; 000000 (R-type) SHALL go to EXECUTE; 000100 (beq) to BRANCH; 001000 (addi) and 001101 (ori) to IMMEXEC; 000010 (j) to JUMP.
REQ-013 Any other op in DECODE SHALL assert illegal_op for exactly that cycle and return to FETCH; no register or memory write SHALL occur.
REQ-014 MEMADR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00 and ext_sel=1, then go to MEMREAD for lw or MEMWRITE for sw.
REQ-015 MEMREAD SHALL drive iord=1 and wait on mem_ready, then go to MEMWB.
REQ-016 MEMWRITE SHALL drive iord=1, hold mem_write=1 until the mem_ready=1 cycle inclusive, then go to FETCH.
REQ-017 MEMWB SHALL drive reg_dst=0, mem_to_reg=1 and reg_write=1 for one cycle, then go to FETCH.
REQ-018 EXECUTE SHALL drive alu_src_a=1, alu_src_b=00 and alu_op=10; ALUWB SHALL drive reg_dst=1, mem_to_reg=0 and reg_write=1, then go to FETCH.
REQ-019 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01 and pc_write_cond=1 for one cycle, then go to FETCH.
REQ-020 IMMEXEC SHALL drive alu_src_a=1 and alu_src_b=10, with alu_op=00 and ext_sel=1 for addi, or alu_op=11 and ext_sel=0 for ori.
REQ-021 IMMWB SHALL drive reg_dst=0, mem_to_reg=0 and reg_write=1, then go to FETCH.
REQ-022 JUMP SHALL drive pc_src=10 and pc_write=1 for one cycle, then go to FETCH.
REQ-023 Every output not listed for a state SHALL be 0, except ext_sel, which SHALL default to 1.
REQ-024 Instruction latencies SHALL be: lw 5, sw 4, R-type 4, addi/ori 4, beq 3 and j 3 cycles, each counted from FETCH entry with mem_ready=1 and each including the mem_ready=1 FETCH cycle; every mem_ready=0 cycle in a memory state SHALL add one cycle.
REQ-025 op SHALL be sampled only in DECODE, MEMADR and IMMEXEC; changes of op in other states SHALL have no effect.

Reset
REQ-026 While rst_n=0, the state SHALL be FETCH and pc_write, ir_write, mem_write, reg_write, pc_write_cond and illegal_op SHALL be forced to 0 combinationally.
REQ-027 Reset asserted mid-instruction SHALL abort that instruction immediately, with no further write enable asserted.
REQ-028 FETCH SHALL be the first state after reset release.

Structure
REQ-029 The state encoding (4-bit), opcode constants and alu_op codes SHALL reside in shared package mips_ctrl_pkg.
REQ-030 A combinational sub-module mips_opcode_decode SHALL map op to a decode class (MEM, RTYPE, BEQ, IMM, JMP, ILLEGAL) and a zero-extend flag.

Verification
REQ-031 Reset pulse mid-MEMWRITE with mem_write=1 -> mem_write=0 immediately; first cycle after release is FETCH.
REQ-032 lw (op=100011), mem_ready=1 throughout -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write=1 in cycle 5 only; mem_to_reg=1.
REQ-033 sw with mem_ready low for 2 cycles in MEMWRITE -> mem_write=1 for 3 cycles; back in FETCH on the cycle after mem_ready=1.
REQ-034 ori (op=001101) -> ext_sel=0 and alu_op=11 in IMMEXEC; addi (op=001000) -> ext_sel=1 and alu_op=00.
REQ-035 op=111111 -> illegal_op=1 for one DECODE cycle, next state FETCH, no reg_write or mem_write.
REQ-036 beq then j back to back -> pc_write_cond=1 in BRANCH only; pc_src=10 with pc_write=1 in JUMP only.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg : state encoding, opcodes and control codes for the multicycle MIPS controller
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_IMMEXEC  = 4'd9,
    S_IMMWB    = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    CLS_MEM     = 3'd0,
    CLS_RTYPE   = 3'd1,
    CLS_BEQ     = 3'd2,
    CLS_IMM     = 3'd3,
    CLS_JMP     = 3'd4,
    CLS_ILLEGAL = 3'd5
  } op_class_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_TARGET = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_opcode_decode.sv
// ---------------------------------------------------------------------------
// mips_opcode_decode : maps the opcode field to a decode class and zero-extend flag
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mips_opcode_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op,
  output op_class_t  op_class,
  output logic       zero_ext
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    zero_ext = 1'b0;
    case (op)
      OP_LW, OP_SW: op_class = CLS_MEM;
      OP_RTYPE:     op_class = CLS_RTYPE;
      OP_BEQ:       op_class = CLS_BEQ;
      OP_ADDI:      op_class = CLS_IMM;
      OP_ORI: begin
        op_class = CLS_IMM;
        zero_ext = 1'b1;
      end
      OP_J:         op_class = CLS_JMP;
      default:      op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control : Moore main-control FSM for a multicycle MIPS datapath
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic       ext_sel,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal_op
);

  state_t    state;
  state_t    state_next;
  op_class_t op_class;
  logic      zero_ext;
  logic      ready;

  logic      pc_write_raw;
  logic      pc_write_cond_raw;
  logic      mem_write_raw;
  logic      ir_write_raw;
  logic      reg_write_raw;
  logic      illegal_op_raw;

  generate
    if (MEM_WAIT_EN) begin : g_mem_wait
      assign ready = mem_ready;
    end else begin : g_no_mem_wait
      assign ready = 1'b1;
    end
  endgenerate

  mips_opcode_decode u_decode (
    .op       (op),
    .op_class (op_class),
    .zero_ext (zero_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next        = state;
    pc_write_raw      = 1'b0;
    pc_write_cond_raw = 1'b0;
    mem_write_raw     = 1'b0;
    ir_write_raw      = 1'b0;
    reg_write_raw     = 1'b0;
    illegal_op_raw    = 1'b0;
    iord              = 1'b0;
    reg_dst           = 1'b0;
    mem_to_reg        = 1'b0;
    alu_src_a         = 1'b0;
    ext_sel           = 1'b1;
    alu_src_b         = SRCB_REG;
    alu_op            = ALU_ADD;
    pc_src            = PC_ALU;

    case (state)
      S_FETCH: begin
        alu_src_b    = SRCB_FOUR;
        ir_write_raw = ready;
        pc_write_raw = ready;
        if (ready) begin
          state_next = S_DECODE;
        end
      end

      // ALU precomputes the branch target while the opcode is classified.
      S_DECODE: begin
        alu_src_b = SRCB_BOFF;
        case (op_class)
          CLS_MEM:   state_next = S_MEMADR;
          CLS_RTYPE: state_next = S_EXECUTE;
          CLS_BEQ:   state_next = S_BRANCH;
          CLS_IMM:   state_next = S_IMMEXEC;
          CLS_JMP:   state_next = S_JUMP;
          default: begin
            illegal_op_raw = 1'b1;
            state_next     = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = is_store(op) ? S_MEMWRITE : S_MEMREAD;
      end

      S_MEMREAD: begin
        iord = 1'b1;
        if (ready) begin
          state_next = S_MEMWB;
        end
      end

      S_MEMWRITE: begin
        iord          = 1'b1;
        mem_write_raw = 1'b1;
        if (ready) begin
          state_next = S_FETCH;
        end
      end

      S_MEMWB: begin
        mem_to_reg    = 1'b1;
        reg_write_raw = 1'b1;
        state_next    = S_FETCH;
      end

      S_EXECUTE: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_FUNCT;
        state_next = S_ALUWB;
      end

      S_ALUWB: begin
        reg_dst       = 1'b1;
        reg_write_raw = 1'b1;
        state_next    = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a         = 1'b1;
        alu_op            = ALU_SUB;
        pc_src            = PC_TARGET;
        pc_write_cond_raw = 1'b1;
        state_next        = S_FETCH;
      end

      S_IMMEXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_op     = zero_ext ? ALU_OR : ALU_ADD;
        ext_sel    = ~zero_ext;
        state_next = S_IMMWB;
      end

      S_IMMWB: begin
        reg_write_raw = 1'b1;
        state_next    = S_FETCH;
      end

      S_JUMP: begin
        pc_src       = PC_JUMP;
        pc_write_raw = 1'b1;
        state_next   = S_FETCH;
      end

      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  // Write enables are gated by reset so an aborted instruction commits nothing.
  assign pc_write      = pc_write_raw      & rst_n;
  assign pc_write_cond = pc_write_cond_raw & rst_n;
  assign mem_write     = mem_write_raw     & rst_n;
  assign ir_write      = ir_write_raw      & rst_n;
  assign reg_write     = reg_write_raw     & rst_n;
  assign illegal_op    = illegal_op_raw    & rst_n;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control : per-instruction expected-output model vs. the controller
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, iord, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, ext_sel;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic       illegal_op;

  int errors = 0;
  int checks = 0;

  string      ph_q[$];
  logic [5:0] op_q[$];
  logic       mr_q[$];

  multicycle_control #(.MEM_WAIT_EN(1'b1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .op            (op),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .ext_sel       (ext_sel),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_src        (pc_src),
    .illegal_op    (illegal_op)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] observed();
    return {pc_write, pc_write_cond, iord, mem_write, ir_write, reg_dst, mem_to_reg,
            reg_write, alu_src_a, ext_sel, alu_src_b, alu_op, pc_src, illegal_op};
  endfunction

  function automatic bit is_legal(input logic [5:0] o);
    return (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000000) ||
           (o == 6'b000100) || (o == 6'b001000) || (o == 6'b001101) || (o == 6'b000010);
  endfunction

  // What each step of an instruction must drive, written straight from the control table.
  function automatic logic [16:0] expect_out(input string ph, input logic [5:0] o, input logic mr);
    logic pcw, pcwc, io, mw, irw, rd, m2r, rw, asa, ext, ill;
    logic [1:0] asb, aop, psrc;
    pcw = 0; pcwc = 0; io = 0; mw = 0; irw = 0; rd = 0; m2r = 0; rw = 0;
    asa = 0; ext = 1; ill = 0; asb = 2'd0; aop = 2'd0; psrc = 2'd0;
    case (ph)
      "FETCH":    begin asb = 2'd1; irw = mr; pcw = mr; end
      "DECODE":   begin asb = 2'd3; ill = !is_legal(o); end
      "MEMADR":   begin asa = 1; asb = 2'd2; end
      "MEMREAD":  begin io = 1; end
      "MEMWRITE": begin io = 1; mw = 1; end
      "MEMWB":    begin m2r = 1; rw = 1; end
      "EXECUTE":  begin asa = 1; aop = 2'd2; end
      "ALUWB":    begin rd = 1; rw = 1; end
      "BRANCH":   begin asa = 1; aop = 2'd1; psrc = 2'd1; pcwc = 1; end
      "IMMEXEC":  begin
        asa = 1; asb = 2'd2;
        if (o == 6'b001101) begin aop = 2'd3; ext = 0; end
      end
      "IMMWB":    begin rw = 1; end
      "JUMP":     begin psrc = 2'd2; pcw = 1; end
      default:    ;
    endcase
    return {pcw, pcwc, io, mw, irw, rd, m2r, rw, asa, ext, asb, aop, psrc, ill};
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom);
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom);
  endfunction

  task automatic push(input string ph, input logic [5:0] o, input logic mr);
    ph_q.push_back(ph);
    op_q.push_back(o);
    mr_q.push_back(mr);
  endtask

  task automatic run_steps();
    logic [16:0] got, exp;
    foreach (ph_q[i]) begin
      @(negedge clk);
      op = op_q[i];
      mem_ready = mr_q[i];
      #1;
      got = observed();
      exp = expect_out(ph_q[i], op_q[i], mr_q[i]);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s step %0d op=%b mr=%b: got %b required %b",
                 ph_q[i], i, op_q[i], mr_q[i], got, exp);
      end
    end
    ph_q.delete();
    op_q.delete();
    mr_q.delete();
  endtask

  // Builds the expected step list of one instruction; op is only meaningful where it is sampled.
  task automatic build_instr(input logic [5:0] o, input int fetch_waits, input int mem_waits);
    repeat (fetch_waits) push("FETCH", rnd_op(), 1'b0);
    push("FETCH", rnd_op(), 1'b1);
    push("DECODE", o, rnd_bit());
    case (o)
      6'b100011: begin
        push("MEMADR", o, rnd_bit());
        repeat (mem_waits) push("MEMREAD", rnd_op(), 1'b0);
        push("MEMREAD", rnd_op(), 1'b1);
        push("MEMWB", rnd_op(), rnd_bit());
      end
      6'b101011: begin
        push("MEMADR", o, rnd_bit());
        repeat (mem_waits) push("MEMWRITE", rnd_op(), 1'b0);
        push("MEMWRITE", rnd_op(), 1'b1);
      end
      6'b000000: begin
        push("EXECUTE", rnd_op(), rnd_bit());
        push("ALUWB", rnd_op(), rnd_bit());
      end
      6'b000100: push("BRANCH", rnd_op(), rnd_bit());
      6'b000010: push("JUMP", rnd_op(), rnd_bit());
      6'b001000, 6'b001101: begin
        push("IMMEXEC", o, rnd_bit());
        push("IMMWB", rnd_op(), rnd_bit());
      end
      default: ;
    endcase
  endtask

  task automatic run_instr(input logic [5:0] o, input int fetch_waits, input int mem_waits);
    build_instr(o, fetch_waits, mem_waits);
    run_steps();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    op = 6'b100011;
    @(negedge clk);
    #1;
    checks++;
    if (observed() !== expect_out("FETCH", op, 1'b0)) begin
      errors++;
      $display("FAIL reset_hold: got %b required %b", observed(), expect_out("FETCH", op, 1'b0));
    end
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (observed() !== expect_out("FETCH", op, 1'b0)) begin
      errors++;
      $display("FAIL reset_release: got %b required %b", observed(), expect_out("FETCH", op, 1'b0));
    end
  endtask

  task automatic test_lw();
    run_instr(6'b100011, 0, 0);
  endtask

  task automatic test_sw_wait();
    run_instr(6'b101011, 1, 2);
  endtask

  task automatic test_imm();
    run_instr(6'b001101, 0, 0);
    run_instr(6'b001000, 0, 0);
  endtask

  task automatic test_illegal();
    run_instr(6'b111111, 0, 0);
    run_instr(6'b000000, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_instr(6'b000100, 0, 0);
    run_instr(6'b000010, 0, 0);
    run_instr(6'b000100, 2, 0);
  endtask

  task automatic test_reset_mid_memwrite();
    logic [16:0] exp;
    push("FETCH", rnd_op(), 1'b1);
    push("DECODE", 6'b101011, 1'b1);
    push("MEMADR", 6'b101011, 1'b1);
    push("MEMWRITE", rnd_op(), 1'b0);
    run_steps();
    #2;
    rst_n = 1'b0;
    #1;
    exp = expect_out("FETCH", op, 1'b0);
    checks++;
    if (mem_write !== 1'b0 || observed() !== exp) begin
      errors++;
      $display("FAIL reset_mid_memwrite: got %b required %b", observed(), exp);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL after_reset_fetch: got %b required %b", observed(), exp);
    end
    run_instr(6'b100011, 0, 1);
  endtask

  task automatic test_random();
    logic [5:0] legal_ops [7];
    logic [5:0] o;
    legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b001101, 6'b000010};
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do o = rnd_op(); while (is_legal(o));
      end else begin
        o = legal_ops[$urandom_range(0, 6)];
      end
      run_instr(o, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_imm();
    test_illegal();
    test_back_to_back();
    test_reset_mid_memwrite();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
